// File: rtl/demux_dist.sv
// demux_dist: routes each accepted input beat to one of 31 output lanes.
// Every lane owns a one-entry holding register (payload + valid bit) that
// is released by that lane's ack. A select of 31 is illegal: the beat is
// accepted, discarded, counted in drop_cnt (saturating) and flagged on err
// for one cycle.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - source presents a beat
//   in_ready  - beat accepted when in_valid & in_ready
//   in_sel    - destination lane 0..30 (31 = illegal, dropped)
//   in_data   - beat payload
//   out_valid - per-lane "holds an unconsumed beat"
//   out_data  - lane k payload at [k*DW +: DW]
//   out_ack   - per-lane consume strobe
//   drop_cnt  - saturating count of dropped beats
//   err       - one-cycle pulse per dropped beat
module demux_dist #(
  parameter int DW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_sel,
  input  logic [DW-1:0]   in_data,
  output logic [30:0]     out_valid,
  output logic [31*DW-1:0] out_data,
  input  logic [30:0]     out_ack,
  output logic [7:0]      drop_cnt,
  output logic            err
);

  localparam int unsigned LANES = 31;

  logic [31:0]   valid_ext;
  logic [31:0]   ack_ext;
  logic [31:0]   sel_onehot;
  logic          accept;
  logic          drop;
  logic [30:0]   load;
  logic [DW-1:0] lane_data [LANES];

  // Pad to 32 entries so in_sel can index directly; entry 31 is never read
  // for readiness because select 31 is always ready.
  assign valid_ext  = {1'b0, out_valid};
  assign ack_ext    = {1'b0, out_ack};
  assign sel_onehot = 32'd1 << in_sel;

  // Readiness depends only on lane state and ack, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    if (in_sel != 5'd31) begin
      in_ready = ~valid_ext[in_sel] | ack_ext[in_sel];
    end
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & (in_sel == 5'd31);
  assign load   = sel_onehot[30:0] & {31{accept}};

  // A load in the same cycle as an ack keeps the lane valid (full throughput);
  // acks on empty lanes have no effect because they only clear set bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
    end else begin
      out_valid <= (out_valid & ~out_ack) | load;
    end
  end

  // Payloads are held after an ack; only a new load overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        lane_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (load[k]) begin
          lane_data[k] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      out_data[k*DW +: DW] = lane_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_dist.sv
// Directed self-checking bench for demux_dist (DW = 2).
module tb_demux_dist;

  localparam int DW = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_sel;
  logic [DW-1:0]   in_data;
  logic [30:0]     out_valid;
  logic [31*DW-1:0] out_data;
  logic [30:0]     out_ack;
  logic [7:0]      drop_cnt;
  logic            err;

  int total = 0;
  int bad   = 0;

  demux_dist #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ack  (out_ack),
    .drop_cnt (drop_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [61:0] exp_data;
  logic [61:0] snap_data;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = '0;
    in_data  = '0;
    out_ack  = '0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_drop",  64'(drop_cnt),  64'd0);
    chk("rst_err",   64'(err),       64'd0);
    #10;
    rst_n = 1'b1;

    // Basic routing to lane 5
    in_valid = 1'b1; in_sel = 5'd5; in_data = 2'b10;
    #1;
    chk("r5_ready0", 64'(in_ready), 64'd1);
    tick();
    in_data = 2'b01;
    #1;
    chk("r5_valid", 64'(out_valid), 64'h20);
    chk("r5_data",  64'(out_data[11:10]), 64'd2);
    chk("r5_full_ready", 64'(in_ready), 64'd0);
    tick();
    chk("r5_hold_valid", 64'(out_valid), 64'h20);
    chk("r5_hold_data",  64'(out_data[11:10]), 64'd2);
    out_ack[5] = 1'b1;
    #1;
    chk("r5_ack_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("r5_reload_valid", 64'(out_valid), 64'h20);
    chk("r5_reload_data",  64'(out_data[11:10]), 64'd1);
    tick();
    out_ack = '0;
    chk("r5_drain_valid", 64'(out_valid), 64'h0);
    chk("r5_drain_data",  64'(out_data[11:10]), 64'd1);

    // Back-to-back streaming on lane 30
    out_ack[30] = 1'b1;
    in_valid = 1'b1; in_sel = 5'd30;
    for (int d = 0; d < 4; d++) begin
      in_data = 2'(d);
      #1;
      chk("s30_ready", 64'(in_ready), 64'd1);
      tick();
      chk("s30_valid", 64'(out_valid[30]), 64'd1);
      chk("s30_data",  64'(out_data[61:60]), 64'(d));
    end
    in_valid = 1'b0;
    tick();
    out_ack = '0;
    chk("s30_drain", 64'(out_valid), 64'h0);

    // Park a beat in lane 2, then illegal selects must not disturb it
    in_valid = 1'b1; in_sel = 5'd2; in_data = 2'b11;
    tick();
    in_sel = 5'd31; in_data = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ill_ready", 64'(in_ready), 64'd1);
      tick();
      chk("ill_err",  64'(err), 64'd1);
      chk("ill_cnt",  64'(drop_cnt), 64'(i + 1));
    end
    chk("ill_valid", 64'(out_valid), 64'h4);
    chk("ill_data2", 64'(out_data[5:4]), 64'd3);
    in_valid = 1'b0;
    tick();
    chk("ill_err_clear", 64'(err), 64'd0);
    chk("ill_cnt_hold",  64'(drop_cnt), 64'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 297; i++) tick();
    chk("sat_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_err", 64'(err), 64'd1);
    tick();
    chk("sat_nowrap", 64'(drop_cnt), 64'd255);
    in_valid = 1'b0;
    tick();
    chk("sat_err_clear", 64'(err), 64'd0);

    // Drain lane 2, then full fan-out
    out_ack[2] = 1'b1;
    tick();
    out_ack = '0;
    chk("l2_drain", 64'(out_valid), 64'h0);
    exp_data = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 31; k++) begin
      in_sel  = 5'(k);
      in_data = k[1:0];
      exp_data[k*2 +: 2] = k[1:0];
      tick();
    end
    in_valid = 1'b0;
    chk("fan_valid", 64'(out_valid), 64'h7FFF_FFFF);
    chk("fan_data",  64'(out_data),  64'(exp_data));
    out_ack = '1;
    tick();
    out_ack = '0;
    chk("fan_clear", 64'(out_valid), 64'h0);
    chk("fan_hold",  64'(out_data),  64'(exp_data));

    // Stray ack on an empty lane
    snap_data = out_data;
    out_ack[7] = 1'b1;
    tick();
    out_ack = '0;
    tick();
    chk("stray_valid", 64'(out_valid), 64'h0);
    chk("stray_data",  64'(out_data),  64'(snap_data));
    chk("stray_cnt",   64'(drop_cnt),  64'd255);
    chk("stray_err",   64'(err),       64'd0);

    // Reset mid-operation with lanes 3, 12 full and drop_cnt = 4
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 5'd3; in_data = 2'b01;
    tick();
    in_sel = 5'd12; in_data = 2'b10;
    tick();
    in_sel = 5'd31;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    chk("pre_valid", 64'(out_valid), 64'h1008);
    chk("pre_cnt",   64'(drop_cnt),  64'd4);
    chk("pre_err",   64'(err),       64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(out_valid), 64'h0);
    chk("mid_data",  64'(out_data),  64'h0);
    chk("mid_cnt",   64'(drop_cnt),  64'd0);
    chk("mid_err",   64'(err),       64'd0);
    #1;
    rst_n = 1'b1;
    in_sel = 5'd3;
    #1;
    chk("post_ready", 64'(in_ready), 64'd1);
    tick();
    chk("post_valid", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
